// File: rtl/syscall_pkg.sv
`default_nettype none
// ============================================================================
// Module      : syscall_pkg
// Description : Shared service codes, FSM state encoding and console beat
//               types for the syscall unit.
// Revision    : 1.0 - initial release
// ============================================================================
package syscall_pkg;

    // $v0 service codes
    localparam logic [31:0] SVC_PRINT_INT  = 32'd1;
    localparam logic [31:0] SVC_PRINT_STR  = 32'd4;
    localparam logic [31:0] SVC_SBRK       = 32'd9;
    localparam logic [31:0] SVC_EXIT       = 32'd10;
    localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EMIT     = 3'd1,
        ST_STR_RD   = 3'd2,
        ST_STR_WAIT = 3'd3,
        ST_STR_EMIT = 3'd4,
        ST_DONE     = 3'd5,
        ST_HALT     = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        CON_INT  = 2'd0,
        CON_CHAR = 2'd1
    } con_type_e;

    // Services that hold the pipeline for more than the issuing cycle
    function automatic logic is_multi_cycle(input logic [31:0] code);
        return (code == SVC_PRINT_INT) || (code == SVC_PRINT_STR) ||
               (code == SVC_PRINT_CHAR) || (code == SVC_EXIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/syscall_unit_heap_alloc.sv
`default_nettype none
// ============================================================================
// Module      : heap_alloc
// Description : sbrk support - rounds the request up to the alignment,
//               checks it against the heap limit and holds the current break
//               plus the sticky allocation-failure flag.
// Revision    : 1.0 - initial release
// ============================================================================
module heap_alloc #(
    parameter logic [31:0] HEAP_BASE  = 32'h0000_0080,
    parameter logic [31:0] HEAP_LIMIT = 32'h0000_1000,
    parameter int          ALIGN_LOG2 = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic [31:0] size_i,
    output logic        fit_o,
    output logic [31:0] heap_ptr_o,
    output logic        heap_err_o
);

    localparam logic [32:0] ALIGN_MASK = (33'd1 << ALIGN_LOG2) - 33'd1;

    logic [31:0] heap_ptr_q;
    logic        heap_err_q;
    logic [32:0] size_w;
    logic [33:0] end_w;

    // Round up in 33 bits so a request near 2**32 cannot wrap to a small size
    assign size_w = ({1'b0, size_i} + ALIGN_MASK) & ~ALIGN_MASK;
    // Extra headroom bit keeps any carry visible to the limit comparison
    assign end_w  = {2'b00, heap_ptr_q} + {1'b0, size_w};
    assign fit_o  = (end_w <= {2'b00, HEAP_LIMIT});

    assign heap_ptr_o = heap_ptr_q;
    assign heap_err_o = heap_err_q;

    // Commit a successful sbrk or latch the failure flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            heap_ptr_q <= HEAP_BASE;
            heap_err_q <= 1'b0;
        end else if (req_i) begin
            if (fit_o) begin
                heap_ptr_q <= end_w[31:0];
            end else begin
                heap_err_q <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/syscall_unit.sv
`default_nettype none
// ============================================================================
// Module      : syscall_unit
// Description : Executes print_int / print_char / print_string / sbrk / exit
//               syscalls, stalling the core while console or memory traffic
//               is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module syscall_unit
    import syscall_pkg::*;
#(
    parameter logic [31:0] HEAP_BASE  = 32'h0000_0080,
    parameter logic [31:0] HEAP_LIMIT = 32'h0000_1000,
    parameter int          ALIGN_LOG2 = 2,
    parameter int          MAX_STR    = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        syscall,
    input  logic [31:0] v0_data,
    input  logic [31:0] a0_data,
    output logic        stall,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        con_valid,
    input  logic        con_ready,
    output logic [1:0]  con_type,
    output logic [31:0] con_data,
    output logic [31:0] heap_ptr,
    output logic        heap_err,
    output logic        halted
);

    localparam int                CNT_W   = $clog2(MAX_STR + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_STR);

    state_e            state_q;
    logic [31:0]       ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              con_valid_q;
    con_type_e         con_type_q;
    logic [31:0]       con_data_q;
    logic              mem_re_q;
    logic              halted_q;

    logic [31:0]       ptr_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              idle_call_w;
    logic              sbrk_req_w;
    logic              fit_w;

    assign ptr_d       = ptr_q + 32'd1;
    assign cnt_d       = cnt_q + 1'b1;
    assign idle_call_w = (state_q == ST_IDLE) && syscall;
    assign sbrk_req_w  = idle_call_w && (v0_data == SVC_SBRK);

    heap_alloc #(
        .HEAP_BASE  (HEAP_BASE),
        .HEAP_LIMIT (HEAP_LIMIT),
        .ALIGN_LOG2 (ALIGN_LOG2)
    ) u_heap_alloc (
        .clk_i      (clk),
        .reset_i    (reset),
        .req_i      (sbrk_req_w),
        .size_i     (a0_data),
        .fit_o      (fit_w),
        .heap_ptr_o (heap_ptr),
        .heap_err_o (heap_err)
    );

    // sbrk answers in the issuing cycle; the core writes $v0 with the instruction
    assign rf_we    = sbrk_req_w && !reset;
    assign rf_wdata = rf_we ? (fit_w ? heap_ptr : 32'hFFFF_FFFF) : 32'd0;

    // Stall covers the entry cycle of multi-cycle services and every busy cycle
    assign stall = !reset &&
                   ((state_q == ST_HALT) ||
                    (syscall && (state_q != ST_IDLE) && (state_q != ST_DONE)) ||
                    (idle_call_w && is_multi_cycle(v0_data)));

    assign mem_re    = mem_re_q;
    assign mem_addr  = ptr_q;
    assign con_valid = con_valid_q;
    assign con_type  = con_type_q;
    assign con_data  = con_data_q;
    assign halted    = halted_q;

    // Service sequencer with registered console and memory strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 32'd0;
            cnt_q       <= '0;
            con_valid_q <= 1'b0;
            con_type_q  <= CON_INT;
            con_data_q  <= 32'd0;
            mem_re_q    <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (syscall) begin
                        case (v0_data)
                            SVC_PRINT_INT: begin
                                con_data_q  <= a0_data;
                                con_type_q  <= CON_INT;
                                con_valid_q <= 1'b1;
                                state_q     <= ST_EMIT;
                            end
                            SVC_PRINT_CHAR: begin
                                con_data_q  <= {24'd0, a0_data[7:0]};
                                con_type_q  <= CON_CHAR;
                                con_valid_q <= 1'b1;
                                state_q     <= ST_EMIT;
                            end
                            SVC_PRINT_STR: begin
                                ptr_q    <= a0_data;
                                cnt_q    <= '0;
                                mem_re_q <= 1'b1;
                                state_q  <= ST_STR_RD;
                            end
                            SVC_EXIT: begin
                                halted_q <= 1'b1;
                                state_q  <= ST_HALT;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_EMIT: begin
                    if (con_ready) begin
                        con_valid_q <= 1'b0;
                        state_q     <= ST_DONE;
                    end
                end
                ST_STR_RD: begin
                    mem_re_q <= 1'b0;
                    state_q  <= ST_STR_WAIT;
                end
                ST_STR_WAIT: begin
                    if (mem_rdata == 8'd0) begin
                        state_q <= ST_DONE;
                    end else begin
                        con_data_q  <= {24'd0, mem_rdata};
                        con_type_q  <= CON_CHAR;
                        con_valid_q <= 1'b1;
                        state_q     <= ST_STR_EMIT;
                    end
                end
                ST_STR_EMIT: begin
                    if (con_ready) begin
                        con_valid_q <= 1'b0;
                        ptr_q       <= ptr_d;
                        cnt_q       <= cnt_d;
                        if (cnt_d == MAX_CNT) begin
                            state_q <= ST_DONE;
                        end else begin
                            mem_re_q <= 1'b1;
                            state_q  <= ST_STR_RD;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_syscall_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_syscall_unit
// Description : Self-checking bench for syscall_unit against a transaction
//               level reference model (console beats, memory reads, heap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_syscall_unit;

    localparam logic [31:0] HB = 32'h0000_0080;
    localparam logic [31:0] HL = 32'h0000_1000;
    localparam int          AL = 2;
    localparam int          MS = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        syscall;
    logic [31:0] v0_data;
    logic [31:0] a0_data;
    logic        stall;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        con_valid;
    logic        con_ready;
    logic [1:0]  con_type;
    logic [31:0] con_data;
    logic [31:0] heap_ptr;
    logic        heap_err;
    logic        halted;

    always #5 clk = ~clk;

    syscall_unit #(
        .HEAP_BASE  (HB),
        .HEAP_LIMIT (HL),
        .ALIGN_LOG2 (AL),
        .MAX_STR    (MS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .syscall   (syscall),
        .v0_data   (v0_data),
        .a0_data   (a0_data),
        .stall     (stall),
        .rf_we     (rf_we),
        .rf_wdata  (rf_wdata),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .con_valid (con_valid),
        .con_ready (con_ready),
        .con_type  (con_type),
        .con_data  (con_data),
        .heap_ptr  (heap_ptr),
        .heap_err  (heap_err),
        .halted    (halted)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [0:1023];

    // reference model state
    logic [31:0] m_heap;
    logic        m_err;

    // observations of the most recent transaction
    logic [33:0] act_beats [$];
    logic [31:0] act_addrs [$];
    int          act_rf_cnt;
    logic [31:0] act_rf;
    int          act_stall;
    bit          tmo;

    int          nbeats;
    int          hold;
    bit          fired;
    bit          nbv;
    logic [7:0]  nb;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one syscall and keep it asserted until the unit releases stall
    task automatic do_call(input logic [31:0] v0, input logic [31:0] a0,
                           input int rdy_pct, input int rdy_delay);
        logic       stall_s;
        logic [7:0] byte_s;
        bit         byte_v;
        int         cyc;
        act_beats.delete();
        act_addrs.delete();
        act_rf_cnt = 0;
        act_rf     = 32'd0;
        act_stall  = 0;
        tmo        = 1'b0;
        syscall    = 1'b1;
        v0_data    = v0;
        a0_data    = a0;
        con_ready  = (rdy_delay == 0) && ($urandom_range(99) < rdy_pct);
        cyc        = 0;
        forever begin
            @(negedge clk);
            byte_v = 1'b0;
            byte_s = 8'd0;
            if (con_valid && con_ready) act_beats.push_back({con_type, con_data});
            if (mem_re) begin
                act_addrs.push_back(mem_addr);
                byte_s = mem[mem_addr[9:0]];
                byte_v = 1'b1;
            end
            if (rf_we) begin
                act_rf_cnt++;
                act_rf = rf_wdata;
            end
            stall_s = stall;
            if (stall_s) act_stall++;
            @(posedge clk);
            #1;
            cyc++;
            mem_rdata = byte_v ? byte_s : 8'($urandom_range(1, 255));
            con_ready = (cyc >= rdy_delay) && ($urandom_range(99) < rdy_pct);
            if (!stall_s) break;
            if (cyc > 500) begin
                tmo = 1'b1;
                break;
            end
        end
        syscall = 1'b0;
        v0_data = $urandom;
        a0_data = $urandom;
    endtask

    // Predict a syscall's effects from the service rules, run it, compare
    task automatic txn(input logic [31:0] v0, input logic [31:0] a0,
                       input int rdy_pct, input int rdy_delay);
        logic [33:0]     eb [$];
        logic [31:0]     ea [$];
        int              erf_cnt;
        logic [31:0]     erf;
        bit              multi;
        logic [31:0]     p;
        longint unsigned size;
        erf_cnt = 0;
        erf     = 32'd0;
        multi   = 1'b0;
        case (v0)
            32'd1: begin
                eb.push_back({2'd0, a0});
                multi = 1'b1;
            end
            32'd11: begin
                eb.push_back({2'd1, 24'd0, a0[7:0]});
                multi = 1'b1;
            end
            32'd4: begin
                multi = 1'b1;
                p = a0;
                for (int n = 0; n < MS; n++) begin
                    ea.push_back(p);
                    if (mem[p[9:0]] == 8'd0) break;
                    eb.push_back({2'd1, 24'd0, mem[p[9:0]]});
                    p = p + 32'd1;
                end
            end
            32'd9: begin
                erf_cnt = 1;
                size = ((longint'(a0) + (2 ** AL) - 1) / (2 ** AL)) * (2 ** AL);
                if (longint'(m_heap) + size <= longint'(HL)) begin
                    erf    = m_heap;
                    m_heap = m_heap + 32'(size);
                end else begin
                    erf   = 32'hFFFF_FFFF;
                    m_err = 1'b1;
                end
            end
            default: ;
        endcase
        do_call(v0, a0, rdy_pct, rdy_delay);
        chk("timeout", 64'(tmo), 64'd0);
        chk("beat_count", 64'(act_beats.size()), 64'(eb.size()));
        for (int i = 0; i < eb.size() && i < act_beats.size(); i++)
            chk("beat", 64'(act_beats[i]), 64'(eb[i]));
        chk("read_count", 64'(act_addrs.size()), 64'(ea.size()));
        for (int i = 0; i < ea.size() && i < act_addrs.size(); i++)
            chk("read_addr", 64'(act_addrs[i]), 64'(ea[i]));
        chk("rf_we_count", 64'(act_rf_cnt), 64'(erf_cnt));
        if (erf_cnt != 0) chk("rf_wdata", 64'(act_rf), 64'(erf));
        chk("heap_ptr", 64'(heap_ptr), 64'(m_heap));
        chk("heap_err", 64'(heap_err), 64'(m_err));
        if (!multi) chk("single_cycle_stall", 64'(act_stall), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        syscall   = 1'b0;
        v0_data   = 32'd0;
        a0_data   = 32'd0;
        mem_rdata = 8'd0;
        con_ready = 1'b0;
        m_heap    = HB;
        m_err     = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
        mem[10'h100] = 8'h48;
        mem[10'h101] = 8'h69;
        mem[10'h102] = 8'h00;
        for (int i = 0; i < 10; i++) mem[10'h200 + i] = 8'(8'h41 + i);
        for (int i = 0; i < 5; i++)  mem[10'h180 + i] = 8'(8'h61 + i);
        for (int i = 10'h300; i < 10'h400; i++)
            mem[i] = ($urandom_range(5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_con_valid", 64'(con_valid), 64'd0);
        chk("rst_mem_re", 64'(mem_re), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_heap_ptr", 64'(heap_ptr), 64'(HB));
        chk("rst_heap_err", 64'(heap_err), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // print_int with the console refusing for three cycles
        txn(32'd1, 32'hDEAD_BEEF, 100, 3);
        chk("int_stall_cycles", 64'(act_stall), 64'd4);
        @(negedge clk);
        chk("int_after_valid", 64'(con_valid), 64'd0);
        chk("int_after_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;

        // "Hi" string
        txn(32'd4, 32'h100, 70, 0);

        // sbrk sequence, zero-size query and overflow
        txn(32'd9, 32'd5, 100, 0);
        chk("sbrk5_ret", 64'(act_rf), 64'h80);
        txn(32'd9, 32'd8, 100, 0);
        chk("sbrk8_ret", 64'(act_rf), 64'h88);
        chk("sbrk_heap_end", 64'(heap_ptr), 64'h90);
        txn(32'd9, 32'd0, 100, 0);
        chk("sbrk0_ret", 64'(act_rf), 64'h90);
        txn(32'd9, 32'hFFFF_FFF0, 100, 0);
        chk("sbrk_ovf_ret", 64'(act_rf), 64'hFFFF_FFFF);
        chk("sbrk_ovf_heap", 64'(heap_ptr), 64'h90);

        // string longer than the per-call limit
        txn(32'd4, 32'h200, 100, 0);

        // randomized mix of services
        for (int t = 0; t < 60; t++) begin
            int          k;
            logic [31:0] v;
            k = $urandom_range(0, 9);
            case (k)
                0, 1: txn(32'd1, $urandom, $urandom_range(30, 100), $urandom_range(0, 3));
                2:    txn(32'd11, $urandom, $urandom_range(30, 100), 0);
                3, 4: txn(32'd4, 32'h300 + $urandom_range(0, 32'hF0), $urandom_range(30, 100), 0);
                5, 6: txn(32'd9, $urandom_range(0, 32'h200), 100, 0);
                7:    txn(32'd9, $urandom, 100, 0);
                default: begin
                    v = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 20);
                    if (v inside {32'd1, 32'd4, 32'd9, 32'd10, 32'd11}) v = 32'd0;
                    txn(v, $urandom, 100, 0);
                end
            endcase
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        // reset while the second of five characters is on offer
        syscall   = 1'b1;
        v0_data   = 32'd4;
        a0_data   = 32'h180;
        con_ready = 1'b1;
        nbeats    = 0;
        fired     = 1'b0;
        for (int c = 0; c < 100 && !fired; c++) begin
            @(negedge clk);
            if (con_valid && nbeats == 1) begin
                reset = 1'b1;
                fired = 1'b1;
            end else begin
                if (con_valid && con_ready) nbeats++;
                nbv = mem_re;
                nb  = mem[mem_addr[9:0]];
                @(posedge clk);
                #1;
                mem_rdata = nbv ? nb : 8'h5A;
            end
        end
        chk("rst_mid_fired", 64'(fired), 64'd1);
        #1;
        chk("rst_mid_valid", 64'(con_valid), 64'd0);
        chk("rst_mid_heap", 64'(heap_ptr), 64'(HB));
        chk("rst_mid_err", 64'(heap_err), 64'd0);
        syscall = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        m_heap = HB;
        m_err  = 1'b0;
        hold   = 0;
        repeat (10) begin
            @(negedge clk);
            if (con_valid || mem_re) hold++;
        end
        chk("rst_mid_quiet", 64'(hold), 64'd0);
        @(posedge clk);
        #1;
        txn(32'd9, 32'd3, 100, 0);

        // exit holds stall until reset
        syscall = 1'b1;
        v0_data = 32'd10;
        a0_data = 32'd0;
        @(posedge clk);
        #1;
        syscall = 1'b0;
        hold    = 0;
        repeat (100) begin
            @(negedge clk);
            if (stall && halted) hold++;
        end
        chk("halt_hold", 64'(hold), 64'd100);
        reset = 1'b1;
        #1;
        chk("halt_rst_halted", 64'(halted), 64'd0);
        chk("halt_rst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        m_heap = HB;
        m_err  = 1'b0;
        @(posedge clk);
        #1;
        txn(32'd11, 32'h1234_5641, 100, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
